regs_bist: RTL
==============

# regs_bist

Built-in self-test controller for the 8×32 two-read/one-write register file (`Regs_8_32`). It drives the register file's write port and both read ports, acting as the initiator for that interface. On `start` it writes a fixed pattern set into all eight registers, reads them back through both read ports, then repeats the sequence with inverted patterns. It reports pass/fail, an error count and the first failing address, and sits beside the register file in the datapath test harness and on the board demo.

## Interface
Parameters: none (geometry fixed at 8 words × 32 bits, 3-bit addresses).

Ports:
- clk — in — 1 — system clock; all state updates on its rising edge.
- cr — in — 1 — reset, synchronous, active-high.
- start — in — 1 — begin a test run; sampled only in IDLE.
- QA — in — 32 — register file read port A data; combinational function of Addr_A.
- QB — in — 32 — register file read port B data; combinational function of Addr_B.
- WE — out — 1 — register file write enable.
- Di — out — 32 — register file write data.
- Addr_W — out — 3 — register file write address.
- Addr_A — out — 3 — read port A address.
- Addr_B — out — 3 — read port B address.
- busy — out — 1 — high while a run is in progress.
- done — out — 1 — one-cycle pulse at the end of a run.
- pass — out — 1 — result of the last completed run; held until the next start.
- err_count — out — 6 — mismatches counted in the current or last run (max 32).
- fail_addr — out — 3 — register address of the first mismatch; valid when err_count≠0.

## Operation
- Pattern: P(i) = 32'hAAAAAAA0 + i when i is even, 32'h55555550 + i when i is odd (i = 0..7). Phase 1 uses P(i); phase 2 uses ~P(i).
- States: IDLE → WR0 → RD0 → WR1 → RD1 → DONE → IDLE. A 3-bit index idx counts 0..7 in each WR/RD state and wraps to 0 on every state change.
- IDLE: WE=0, busy=0. If start=1, clear err_count and fail_addr, clear pass, and go to WR0.
- WR0/WR1: WE=1, Addr_W=idx, Di=P(idx) (WR0) or ~P(idx) (WR1). After idx=7, go to RD0/RD1.
- RD0/RD1: WE=0, Addr_A=idx, Addr_B=7−idx. At each edge, compare QA against the expected value for idx and QB against the expected value for 7−idx. Each mismatching port adds 1 to err_count. On the first mismatch of the run, fail_addr captures the failing address, taking port A's address if both ports mismatch. After idx=7, go to WR1 or DONE.
- DONE: done=1, pass=(err_count==0), busy=0 from the next cycle, then return to IDLE.
- Outputs WE, Di and Addr_* are decoded from the state and idx registers only (Moore outputs). Outside the WR states, Di=0 and Addr_W=0. Outside the RD states, Addr_A=0 and Addr_B=0.
- start is ignored while busy. If start is held high, a new run begins in the cycle after DONE.
- err_count cannot exceed 32, so no saturation is needed.

## Timing
- Reset values, applied at the first edge with cr=1: state=IDLE, idx=0, WE=0, Di=0, Addr_W/A/B=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0.
- cr has priority over start and over every state transition. Asserting cr mid-run aborts the run; WE is low from the cycle after that edge, and no done pulse occurs.
- Latency: start is sampled at edge E0. The state is WR0 in cycles 1–8, RD0 in 9–16, WR1 in 17–24, RD1 in 25–32 and DONE in cycle 33; busy is high in cycles 1–32. The run is 33 cycles from start to done.
- Write timing: the register file captures Di at the edge ending each WR cycle. Read data written at the last WR edge is visible in the first RD cycle.
- Read timing: QA/QB must settle within the cycle; they are sampled at the edge ending each RD cycle.

## Test plan
- Reset: hold cr=1 for 2 cycles with start=1 → all outputs at their reset values and busy stays 0.
- Clean run against a fault-free register file: pulse start → WE high exactly 16 cycles. The written values are addr0=AAAAAAA0, addr1=55555551 … addr7=55555557, then addr0=5555555F, addr1=AAAAAAAE. done pulses in cycle 33 with pass=1 and err_count=0.
- Stuck-at fault: the bench model forces reg3 bit0 to 1 → phase 1 is clean and phase 2 reads AAAAAAAD against expected AAAAAAAC. Result: err_count=2 (QA at idx3, QB at idx4), fail_addr=3, pass=0.
- Dead write port: the model ignores WE and all registers read 0 → err_count=32, fail_addr=0, pass=0.
- Abort and retrigger: assert cr for 1 cycle at cycle 12 (in RD0) → IDLE with WE=0 next cycle and no done pulse. A new start then runs the full 33 cycles and passes.
- Start handling: pulse start again during cycle 20 → ignored, and done occurs only in cycle 33. Hold start high continuously → back-to-back runs, with each done pulse 34 cycles apart.

Source files
------------

// File: rtl/regs_bist.sv
// regs_bist: self-test controller for the 8x32 two-read/one-write register file.
// It writes a pattern set into all eight words, reads every word back through
// both read ports, then repeats with the inverted patterns. It reports
// pass/fail, a mismatch count and the first failing address.
module regs_bist (
   input  logic        clk,
   input  logic        cr,
   input  logic        start,
   input  logic [31:0] QA,
   input  logic [31:0] QB,
   output logic        WE,
   output logic [31:0] Di,
   output logic [2:0]  Addr_W,
   output logic [2:0]  Addr_A,
   output logic [2:0]  Addr_B,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [5:0]  err_count,
   output logic [2:0]  fail_addr
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR0  = 3'd1,
      S_RD0  = 3'd2,
      S_WR1  = 3'd3,
      S_RD1  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Base pattern: even words alternate 1010..., odd words 0101..., with the
   // word index in the low nibble so address aliasing also shows up.
   function automatic logic [31:0] pattern(input logic [2:0] i);
      logic [31:0] base;
      base = i[0] ? 32'h55555550 : 32'hAAAAAAA0;
      return base + {29'd0, i};
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [5:0]  err_count_q, err_count_d;
   logic [2:0]  fail_addr_q, fail_addr_d;
   logic        pass_q, pass_d;
   logic        we_q, we_d;
   logic [31:0] di_q, di_d;
   logic [2:0]  addr_w_q, addr_w_d;
   logic [2:0]  addr_a_q, addr_a_d;
   logic [2:0]  addr_b_q, addr_b_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Read-check helpers for the current RD cycle.
   logic        phase2;
   logic [2:0]  idx_b;
   logic [31:0] exp_a, exp_b;
   logic        miss_a, miss_b;
   logic        in_rd;

   // Expected read data and mismatch flags; port B walks the addresses in reverse.
   always_comb begin
      in_rd  = (state_q == S_RD0) || (state_q == S_RD1);
      phase2 = (state_q == S_RD1);
      idx_b  = 3'd7 - idx_q;
      exp_a  = pattern(idx_q) ^ {32{phase2}};
      exp_b  = pattern(idx_b) ^ {32{phase2}};
      miss_a = in_rd && (QA != exp_a);
      miss_b = in_rd && (QB != exp_b);
   end

   // Next-state, index, result bookkeeping, and Moore output decode of the next state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_count_d = err_count_q;
      fail_addr_d = fail_addr_q;
      pass_d      = pass_q;

      case (state_q)
         S_IDLE: begin
            idx_d = 3'd0;
            if (start) begin
               err_count_d = 6'd0;
               fail_addr_d = 3'd0;
               pass_d      = 1'b0;
               state_d     = S_WR0;
            end
         end
         S_WR0, S_WR1: begin
            // idx wraps 7 -> 0 naturally as the state advances
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7)
               state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
         end
         S_RD0, S_RD1: begin
            idx_d       = idx_q + 3'd1;
            err_count_d = err_count_q + {5'd0, miss_a} + {5'd0, miss_b};
            // an err count of zero means no mismatch has been seen this run yet
            if ((err_count_q == 6'd0) && (miss_a || miss_b))
               fail_addr_d = miss_a ? idx_q : idx_b;
            if (idx_q == 3'd7) begin
               if (state_q == S_RD0) begin
                  state_d = S_WR1;
               end else begin
                  state_d = S_DONE;
                  pass_d  = (err_count_d == 6'd0);
               end
            end
         end
         S_DONE: begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
         end
         default: begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are a pure function of (state, idx); computing them from the
      // next values lets them come straight out of flops.
      we_d     = (state_d == S_WR0) || (state_d == S_WR1);
      di_d     = 32'd0;
      addr_w_d = 3'd0;
      addr_a_d = 3'd0;
      addr_b_d = 3'd0;
      if (we_d) begin
         di_d     = pattern(idx_d) ^ {32{state_d == S_WR1}};
         addr_w_d = idx_d;
      end
      if ((state_d == S_RD0) || (state_d == S_RD1)) begin
         addr_a_d = idx_d;
         addr_b_d = 3'd7 - idx_d;
      end
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; cr wins over everything and aborts a run.
   always_ff @(posedge clk) begin
      if (cr) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         err_count_q <= 6'd0;
         fail_addr_q <= 3'd0;
         pass_q      <= 1'b0;
         we_q        <= 1'b0;
         di_q        <= 32'd0;
         addr_w_q    <= 3'd0;
         addr_a_q    <= 3'd0;
         addr_b_q    <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_count_q <= err_count_d;
         fail_addr_q <= fail_addr_d;
         pass_q      <= pass_d;
         we_q        <= we_d;
         di_q        <= di_d;
         addr_w_q    <= addr_w_d;
         addr_a_q    <= addr_a_d;
         addr_b_q    <= addr_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign WE        = we_q;
   assign Di        = di_q;
   assign Addr_W    = addr_w_q;
   assign Addr_A    = addr_a_q;
   assign Addr_B    = addr_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign fail_addr = fail_addr_q;

endmodule
